// File: rtl/fifo_event_serializer.sv
// fifo_event_serializer
// Drains DWIDTH-bit event words from a show-ahead FIFO and streams each word
// out LSB-first as NBEATS beats of OWIDTH bits on a valid/ready master port.
// A new word is popped in the same cycle the previous word's last beat is
// accepted, so a non-empty FIFO with m_ready held high streams without gaps.
module fifo_event_serializer #(
    parameter int DWIDTH = 136,
    parameter int OWIDTH = 32,
    parameter int CWIDTH = 16,
    localparam int NBEATS = (DWIDTH + OWIDTH - 1) / OWIDTH,
    localparam int BWIDTH = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OWIDTH-1:0] m_data,
    output logic              m_last,
    output logic [BWIDTH-1:0] m_beat,
    output logic [CWIDTH-1:0] word_count,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Holding word padded up to a whole number of beats; the pad bits are
    // constant zero so the final beat is zero-filled above the word's MSB.
    localparam int PWIDTH = NBEATS * OWIDTH;
    localparam logic [BWIDTH-1:0] LAST_BEAT = BWIDTH'(NBEATS - 1);

    // A beat wider than the event word has no meaning; stop elaboration.
    generate
        if (OWIDTH < 1 || OWIDTH > DWIDTH) begin : g_bad_owidth
            $error("fifo_event_serializer: OWIDTH must be in 1..DWIDTH");
        end
    endgenerate

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [DWIDTH-1:0] hold_reg;
    logic [DWIDTH-1:0] hold_next;
    logic [BWIDTH-1:0] beat_reg;
    logic [BWIDTH-1:0] beat_next;
    logic [CWIDTH-1:0] word_count_reg;
    logic [CWIDTH-1:0] word_count_next;

    logic [PWIDTH-1:0] hold_pad;
    logic [OWIDTH-1:0] beat_word [NBEATS];

    logic sending;
    logic is_last;
    logic handshake;
    logic word_done;

    // Channel status derived purely from registered state, so m_valid never
    // depends combinationally on m_ready.
    assign sending   = (state_reg == ST_SEND);
    assign is_last   = (beat_reg == LAST_BEAT);
    assign handshake = sending & m_ready;
    assign word_done = handshake & is_last;

    // Pop whenever idle with data, or when the last beat leaves and another
    // word is already at the head. Never pops during reset or while empty.
    assign fifo_rd_en = !rst & !fifo_empty & (!sending | word_done);

    // Zero-extend the holding word to the padded beat grid.
    always_comb begin
        hold_pad               = '0;
        hold_pad[DWIDTH-1:0]   = hold_reg;
    end

    // Slice the padded word into its beats, beat 0 = least significant.
    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
            assign beat_word[gi] = hold_pad[gi*OWIDTH +: OWIDTH];
        end
    endgenerate

    assign m_valid    = sending;
    assign busy       = sending;
    assign m_last     = sending & is_last;
    assign m_beat     = beat_reg;
    assign m_data     = sending ? beat_word[beat_reg] : '0;
    assign word_count = word_count_reg;

    // Next-state selection: reload takes priority over retiring the word.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        beat_next  = beat_reg;
        if (fifo_rd_en) begin
            state_next = ST_SEND;
            hold_next  = fifo_rdata;
            beat_next  = '0;
        end else if (word_done) begin
            state_next = ST_IDLE;
            beat_next  = '0;
        end else if (handshake) begin
            beat_next  = beat_reg + 1'b1;
        end
    end

    // Completed-word counter; wraps silently.
    always_comb begin
        word_count_next = word_count_reg;
        if (word_done) begin
            word_count_next = word_count_reg + 1'b1;
        end
    end

    // State, holding word and beat index; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            hold_reg  <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            beat_reg  <= beat_next;
        end
    end

    // Word counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_reg <= '0;
        end else begin
            word_count_reg <= word_count_next;
        end
    end

endmodule

// File: tb/tb_fifo_event_serializer.sv
// Testbench for fifo_event_serializer: a queue-based FIFO model feeds the DUT,
// a scoreboard of expected beats (computed by shifting whole words) checks
// every accepted beat, plus a table of known words and directed sequences.
module tb_fifo_event_serializer;

    logic         clk;
    logic         rst;
    logic         fifo_empty;
    logic [135:0] fifo_rdata;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         m_last;
    logic [2:0]   m_beat;
    logic [15:0]  word_count;
    logic         busy;

    // Second instance: one full-width beat per word, 4-bit counter.
    logic         w_rst;
    logic         w_empty;
    logic [135:0] w_rdata;
    logic         w_rd_en;
    logic         w_valid;
    logic         w_ready;
    logic [135:0] w_data;
    logic         w_last;
    logic [0:0]   w_beat;
    logic [3:0]   w_wc;
    logic         w_busy;

    fifo_event_serializer u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_beat(m_beat),
        .word_count(word_count), .busy(busy)
    );

    fifo_event_serializer #(.DWIDTH(136), .OWIDTH(136), .CWIDTH(4)) u_wide (
        .clk(clk), .rst(w_rst), .fifo_empty(w_empty), .fifo_rdata(w_rdata),
        .fifo_rd_en(w_rd_en), .m_valid(w_valid), .m_ready(w_ready),
        .m_data(w_data), .m_last(w_last), .m_beat(w_beat),
        .word_count(w_wc), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [2:0]  idx;
    } exp_t;

    typedef struct {
        logic [135:0]     word;
        logic [4:0][31:0] beats;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [135:0] fifo_q [$];
    exp_t         exp_q [$];
    logic [15:0]  model_wc = '0;

    // Sampled DUT values for the cycle just stepped
    logic        s_rst, s_empty, s_rd, s_valid, s_ready, s_last, s_busy;
    logic [31:0] s_data;
    logic [2:0]  s_beat;
    logic [15:0] s_wc;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [31:0] p_data = '0;
    logic [2:0]  p_beat = '0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [135:0] rand_word();
        return {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic expect_word(input logic [135:0] w);
        for (int i = 0; i < 5; i++) begin
            logic [135:0] sh;
            exp_t e;
            sh = w >> (32 * i);
            e.data = sh[31:0];
            e.last = (i == 4);
            e.idx  = 3'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [135:0] w);
        fifo_q.push_back(w);
        expect_word(w);
        drive_fifo();
    endtask

    // One clock: sample mid-cycle, score the cycle, then advance the FIFO model.
    task automatic step();
        #4;
        s_rst = rst; s_empty = fifo_empty; s_rd = fifo_rd_en; s_valid = m_valid;
        s_ready = m_ready; s_last = m_last; s_busy = busy; s_data = m_data;
        s_beat = m_beat; s_wc = word_count;
        check("rd_en_while_empty", 136'(s_rd & s_empty), 136'(0));
        if (!s_rst) begin
            check("word_count", 136'(s_wc), 136'(model_wc));
            check("busy_eq_valid", 136'(s_busy), 136'(s_valid));
            check("last_without_valid", 136'(s_last & !s_valid), 136'(0));
            if (p_valid && !p_ready) begin
                check("stall_valid", 136'(s_valid), 136'(1));
                check("stall_data", 136'(s_data), 136'(p_data));
                check("stall_beat", 136'(s_beat), 136'(p_beat));
                check("stall_last", 136'(s_last), 136'(p_last));
            end
            if (s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 136'(s_data), 136'(0));
                    total_cnt++;
                    $display("FAIL unexpected_beat actual=beat %0d required=no beat", s_beat);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", 136'(s_data), 136'(e.data));
                    check("sb_last", 136'(s_last), 136'(e.last));
                    check("sb_beat", 136'(s_beat), 136'(e.idx));
                    if (e.last) model_wc = model_wc + 16'd1;
                end
            end
        end
        p_valid = s_valid; p_ready = s_ready; p_last = s_last;
        p_data = s_data; p_beat = s_beat;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (s_rst) begin
            // Partial word is discarded; the stream restarts at the FIFO head.
            p_valid = 1'b0;
            model_wc = '0;
            exp_q.delete();
            foreach (fifo_q[k]) expect_word(fifo_q[k]);
        end
        drive_fifo();
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            if (!s_valid && !s_rd && fifo_q.size() == 0) done = 1'b1;
        end
        check("drain_done", 136'(done), 136'(1));
        check("drain_sb_empty", 136'(exp_q.size()), 136'(0));
    endtask

    vec_t vecs [4];

    initial begin
        int n_valid, n_rd, first_v, last_v;
        logic [15:0] wc0;
        logic [135:0] wa, wb;

        vecs[0].word  = 136'hAB_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;
        vecs[0].beats = {32'h000000AB, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999};
        vecs[1].word  = {136{1'b1}};
        vecs[1].beats = {32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2].word  = 136'h12_87654321_0FEDCBA9_DEADBEEF_00000001;
        vecs[2].beats = {32'h00000012, 32'h87654321, 32'h0FEDCBA9, 32'hDEADBEEF, 32'h00000001};
        vecs[3].word  = 136'h80_00000000_00000000_00000000_00000000;
        vecs[3].beats = {32'h00000080, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

        rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
        w_rst = 1'b1; w_empty = 1'b1; w_rdata = '0; w_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        step();
        check("rst_valid", 136'(s_valid), 136'(0));
        check("rst_last", 136'(s_last), 136'(0));
        check("rst_beat", 136'(s_beat), 136'(0));
        check("rst_data", 136'(s_data), 136'(0));
        check("rst_wc", 136'(s_wc), 136'(0));
        check("rst_busy", 136'(s_busy), 136'(0));
        rst = 1'b0;
        step();

        // Table of known words, m_ready held high
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_word(vecs[k].word);
            step();
            check("tbl_pop", 136'(s_rd), 136'(1));
            check("tbl_no_valid_yet", 136'(s_valid), 136'(0));
            for (int i = 0; i < 5; i++) begin
                step();
                check("tbl_valid", 136'(s_valid), 136'(1));
                check("tbl_data", 136'(s_data), 136'(vecs[k].beats[i]));
                check("tbl_beat", 136'(s_beat), 136'(i));
                check("tbl_last", 136'(s_last), 136'(i == 4));
                check("tbl_no_pop", 136'(s_rd), 136'(0));
            end
            step();
            check("tbl_idle", 136'(s_valid), 136'(0));
            check("tbl_wc", 136'(s_wc), 136'(k + 1));
            $display("table word %0d done, word_count=%0d", k, s_wc);
        end

        // Back-to-back: three queued words, no gaps
        for (int k = 0; k < 3; k++) push_word(rand_word());
        n_valid = 0; n_rd = 0; first_v = -1; last_v = -1; wc0 = '0;
        for (int c = 0; c < 17; c++) begin
            step();
            if (c == 0) wc0 = s_wc;
            if (s_valid) begin
                n_valid++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (s_rd) n_rd++;
        end
        check("b2b_valid_beats", 136'(n_valid), 136'(15));
        check("b2b_contiguous", 136'(last_v - first_v + 1), 136'(15));
        check("b2b_pops", 136'(n_rd), 136'(3));
        check("b2b_wc", 136'(s_wc), 136'(wc0 + 16'd3));
        $display("back-to-back: beats=%0d pops=%0d", n_valid, n_rd);

        // Backpressure on beat 2 with a second word queued
        wa = rand_word();
        push_word(wa);
        push_word(rand_word());
        step(); step(); step();
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("bp_valid", 136'(s_valid), 136'(1));
            check("bp_beat", 136'(s_beat), 136'(2));
            check("bp_data", 136'(s_data), 136'(wa[95:64]));
            check("bp_no_pop", 136'(s_rd), 136'(0));
        end
        drain();
        $display("backpressure sequence done");

        // Empty stall then a single arrival
        for (int c = 0; c < 10; c++) begin
            step();
            check("empty_no_pop", 136'(s_rd), 136'(0));
            check("empty_no_valid", 136'(s_valid), 136'(0));
        end
        wa = rand_word();
        push_word(wa);
        step();
        check("arrive_pop", 136'(s_rd), 136'(1));
        check("arrive_not_valid", 136'(s_valid), 136'(0));
        step();
        check("arrive_valid", 136'(s_valid), 136'(1));
        check("arrive_data", 136'(s_data), 136'(wa[31:0]));
        drain();
        $display("empty stall sequence done");

        // Reset during beat 3 of word A with word B queued
        wa = rand_word(); wb = rand_word();
        push_word(wa); push_word(wb);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        check("rstmid_beat3", 136'(s_beat), 136'(3));
        check("rstmid_no_pop", 136'(s_rd), 136'(0));
        rst = 1'b0;
        step();
        check("rstmid_idle", 136'(s_valid), 136'(0));
        check("rstmid_wc", 136'(s_wc), 136'(0));
        check("rstmid_pop_b", 136'(s_rd), 136'(1));
        step();
        check("rstmid_b_valid", 136'(s_valid), 136'(1));
        check("rstmid_b_beat", 136'(s_beat), 136'(0));
        check("rstmid_b_data", 136'(s_data), 136'(wb[31:0]));
        drain();
        $display("reset mid-word sequence done");

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 2000; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0 && fifo_q.size() < 6) push_word(rand_word());
            step();
        end
        drain();
        $display("random traffic done, word_count=%0d", s_wc);

        // Full-width instance: every beat last, 4-bit counter wraps
        begin
            logic [135:0] wq [$];
            int n_acc;
            logic done;
            n_acc = 0; done = 1'b0;
            w_rst = 1'b1;
            @(posedge clk); #1;
            w_rst = 1'b0; w_empty = 1'b0; w_rdata = rand_word();
            for (int c = 0; c < 200 && !done; c++) begin
                w_ready = ($urandom_range(0, 4) != 0);
                #4;
                check("w_rd_gate", 136'(w_rd_en & w_empty), 136'(0));
                check("w_wc", 136'(w_wc), 136'(n_acc % 16));
                if (n_acc == 16) check("w_wrap16", 136'(w_wc), 136'(0));
                if (n_acc == 17) begin
                    check("w_wrap17", 136'(w_wc), 136'(1));
                    done = 1'b1;
                end
                if (w_valid) begin
                    check("w_last", 136'(w_last), 136'(1));
                    check("w_beat", 136'(w_beat), 136'(0));
                end
                if (w_valid && w_ready) begin
                    if (wq.size() > 0) check("w_data", w_data, wq.pop_front());
                    else check("w_unexpected", 136'(1), 136'(0));
                    n_acc++;
                end
                if (w_rd_en) wq.push_back(w_rdata);
                @(posedge clk); #1;
                w_rdata = rand_word();
            end
            check("w_done", 136'(done), 136'(1));
            $display("wide instance: %0d words accepted, word_count=%0d", n_acc, w_wc);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
